// File: rtl/obstacle_lane_manager.sv
// N-lane obstacle engine: per-lane obstacle slots that spawn, scroll once per frame,
// raise collision pulses against the grounded player and render a flat-colour sprite.
module obstacle_lane_manager #(
    parameter int          NUM_LANES  = 3,
    parameter logic [15:0] LANE_X0    = 16'd160,
    parameter logic [15:0] LANE_PITCH = 16'd120,
    parameter logic [15:0] OBS_W      = 16'd64,
    parameter logic [15:0] OBS_H      = 16'd32,
    parameter logic [15:0] SPEED      = 16'd4,
    parameter logic [15:0] HIT_Y_MIN  = 16'd400,
    parameter logic [15:0] HIT_Y_MAX  = 16'd440,
    parameter logic [15:0] SCREEN_H   = 16'd480,
    parameter logic [23:0] OBS_RGB    = 24'hC04020
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_tick,
    input  logic                 i_spawn_valid,
    input  logic [2:0]           i_spawn_lane,
    output logic                 o_spawn_ready,
    input  logic [2:0]           i_player_lane,
    input  logic                 i_in_air,
    input  logic [15:0]          i_x,
    input  logic [15:0]          i_y,
    output logic [7:0]           o_red,
    output logic [7:0]           o_green,
    output logic [7:0]           o_blue,
    output logic                 o_sprite_hit,
    output logic                 o_hit,
    output logic [2:0]           o_hit_lane,
    output logic [NUM_LANES-1:0] o_lane_active,
    output logic [15:0]          o_passed_count
);

    typedef enum logic {SLOT_IDLE, SLOT_ACTIVE} slot_state_e;

    slot_state_e          state_q [NUM_LANES];
    slot_state_e          state_d [NUM_LANES];
    logic [15:0]          y_q     [NUM_LANES];
    logic [15:0]          y_d     [NUM_LANES];
    logic [NUM_LANES-1:0] spawn_sel, hit_sel, retire_sel;

    logic        hit_q, hit_d;
    logic [2:0]  hit_lane_q, hit_lane_d;
    logic [15:0] count_q, count_d;
    logic        sprite_q, sprite_d;
    logic [23:0] rgb_q, rgb_d;

    // Lanes beyond NUM_LANES never match, so they can never report ready.
    always_comb begin : spawn_decode
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_spawn_ready = 1'b0;
        spawn_sel     = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_spawn_lane == 3'(k) && state_q[k] == SLOT_IDLE) o_spawn_ready = 1'b1;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            spawn_sel[k] = i_spawn_valid && o_spawn_ready && (i_spawn_lane == 3'(k));
        end
    end

    always_comb begin : slot_next_state
        for (int k = 0; k < NUM_LANES; k++) begin : lane
            logic [16:0] y_n;
            y_n           = {1'b0, y_q[k]} + {1'b0, SPEED};
            state_d[k]    = state_q[k];
            y_d[k]        = y_q[k];
            hit_sel[k]    = 1'b0;
            retire_sel[k] = 1'b0;
            case (state_q[k])
                SLOT_IDLE: begin
                    if (spawn_sel[k]) begin
                        state_d[k] = SLOT_ACTIVE;
                        y_d[k]     = '0;
                    end
                end
                SLOT_ACTIVE: begin
                    if (i_frame_tick) begin
                        if (i_player_lane == 3'(k) && !i_in_air &&
                            y_n >= {1'b0, HIT_Y_MIN} && y_n <= {1'b0, HIT_Y_MAX}) begin
                            hit_sel[k] = 1'b1;
                            state_d[k] = SLOT_IDLE;
                        end else if (y_n >= {1'b0, SCREEN_H}) begin
                            retire_sel[k] = 1'b1;
                            state_d[k]    = SLOT_IDLE;
                        end else begin
                            y_d[k] = y_n[15:0];
                        end
                    end
                end
                default: state_d[k] = SLOT_IDLE;
            endcase
        end
    end

    always_comb begin : slot_outputs
        for (int k = 0; k < NUM_LANES; k++) o_lane_active[k] = (state_q[k] == SLOT_ACTIVE);
    end

    // Lowest colliding lane wins the report; retirements on one tick are summed.
    always_comb begin : event_logic
        logic [3:0]  retire_n;
        logic [16:0] count_sum;
        hit_d      = |hit_sel;
        hit_lane_d = hit_lane_q;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (hit_sel[k]) hit_lane_d = 3'(k);
        end
        retire_n = '0;
        for (int k = 0; k < NUM_LANES; k++) retire_n = retire_n + 4'(retire_sel[k]);
        count_sum = {1'b0, count_q} + 17'(retire_n);
        count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    always_comb begin : render
        logic [16:0] lane_x;
        sprite_d = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_x = {1'b0, LANE_X0} + 17'(k) * {1'b0, LANE_PITCH};
            if (o_lane_active[k] &&
                {1'b0, i_x} >= lane_x && {1'b0, i_x} < lane_x + {1'b0, OBS_W} &&
                i_y >= y_q[k] && {1'b0, i_y} < {1'b0, y_q[k]} + {1'b0, OBS_H}) begin
                sprite_d = 1'b1;
            end
        end
        rgb_d = sprite_d ? OBS_RGB : 24'h0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : slot_regs
        if (!i_rst_n) begin
            // NOTE: the y array is tiny and must read 0 after reset, so it is reset like ordinary flops.
            for (int k = 0; k < NUM_LANES; k++) begin
                state_q[k] <= SLOT_IDLE;
                y_q[k]     <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            for (int k = 0; k < NUM_LANES; k++) begin
                state_q[k] <= state_d[k];
                y_q[k]     <= y_d[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : out_regs
        if (!i_rst_n) begin
            hit_q      <= 1'b0;
            hit_lane_q <= '0;
            count_q    <= '0;
            sprite_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            hit_q      <= hit_d;
            hit_lane_q <= hit_lane_d;
            count_q    <= count_d;
            sprite_q   <= sprite_d;
            rgb_q      <= rgb_d;
        end
    end

    assign o_hit          = hit_q;
    assign o_hit_lane     = hit_lane_q;
    assign o_passed_count = count_q;
    assign o_sprite_hit   = sprite_q;
    assign o_red          = rgb_q[23:16];
    assign o_green        = rgb_q[15:8];
    assign o_blue         = rgb_q[7:0];

endmodule

// File: tb/tb_obstacle_lane_manager.sv
// Scoreboard bench for obstacle_lane_manager: a behavioural lane model pushes the expected
// event/count/active state per cycle, which is popped and compared after the clock edge.
module tb_obstacle_lane_manager;

    localparam int NL = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_frame_tick = 1'b0;
    logic          i_spawn_valid = 1'b0;
    logic [2:0]    i_spawn_lane = '0;
    logic          o_spawn_ready;
    logic [2:0]    i_player_lane = '0;
    logic          i_in_air = 1'b0;
    logic [15:0]   i_x = '0;
    logic [15:0]   i_y = '0;
    logic [7:0]    o_red, o_green, o_blue;
    logic          o_sprite_hit;
    logic          o_hit;
    logic [2:0]    o_hit_lane;
    logic [NL-1:0] o_lane_active;
    logic [15:0]   o_passed_count;

    always #5 i_clk = ~i_clk;

    obstacle_lane_manager #(.NUM_LANES(NL)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick),
        .i_spawn_valid(i_spawn_valid), .i_spawn_lane(i_spawn_lane), .o_spawn_ready(o_spawn_ready),
        .i_player_lane(i_player_lane), .i_in_air(i_in_air), .i_x(i_x), .i_y(i_y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_sprite_hit(o_sprite_hit),
        .o_hit(o_hit), .o_hit_lane(o_hit_lane), .o_lane_active(o_lane_active),
        .o_passed_count(o_passed_count)
    );

    typedef struct {
        logic          hit;
        logic [2:0]    lane;
        logic [15:0]   cnt;
        logic [NL-1:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_act[NL];
    int   m_y[NL];
    int   m_cnt = 0;
    int   m_hit_lane = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NL; k++) begin
            m_act[k] = 1'b0;
            m_y[k]   = 0;
        end
        m_cnt      = 0;
        m_hit_lane = 0;
    endfunction

    function automatic bit model_tick(input int plane, input bit air);
        bit hit = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (m_act[k]) begin
                int yn = m_y[k] + 4;
                if (k == plane && !air && yn >= 400 && yn <= 440) begin
                    m_act[k] = 1'b0;
                    if (!hit) begin
                        hit        = 1'b1;
                        m_hit_lane = k;
                    end
                end else if (yn >= 480) begin
                    m_act[k] = 1'b0;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_y[k] = yn;
                end
            end
        end
        return hit;
    endfunction

    function automatic bit model_pixel(input int x, input int y);
        bit hit = 1'b0;
        for (int k = 0; k < NL; k++) begin
            int lx = 160 + 120 * k;
            if (m_act[k] && x >= lx && x < lx + 64 && y >= m_y[k] && y < m_y[k] + 32) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic push_expect(input bit hit);
        exp_t e;
        e.hit  = hit;
        e.lane = 3'(m_hit_lane);
        e.cnt  = 16'(m_cnt);
        for (int k = 0; k < NL; k++) e.act[k] = m_act[k];
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        check("queue_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("hit", o_hit, e.hit);
            check("hit_lane", o_hit_lane, e.lane);
            check("passed_count", o_passed_count, e.cnt);
            check("lane_active", o_lane_active, e.act);
        end
    endtask

    task automatic tick(input int plane, input bit air);
        i_player_lane = 3'(plane);
        i_in_air      = air;
        i_frame_tick  = 1'b1;
        push_expect(model_tick(plane, air));
        step();
        i_frame_tick = 1'b0;
        compare_out();
    endtask

    task automatic ticks(input int n, input int plane, input bit air);
        for (int i = 0; i < n; i++) tick(plane, air);
    endtask

    task automatic spawn(input int lane, input bit with_tick, input int plane, input bit air);
        bit exp_ready = 1'b0;
        bit hit = 1'b0;
        if (lane < NL) exp_ready = !m_act[lane];
        i_spawn_valid = 1'b1;
        i_spawn_lane  = 3'(lane);
        i_frame_tick  = with_tick;
        i_player_lane = 3'(plane);
        i_in_air      = air;
        #1;
        check("spawn_ready", o_spawn_ready, exp_ready);
        if (with_tick) hit = model_tick(plane, air);
        if (exp_ready) begin
            m_act[lane] = 1'b1;
            m_y[lane]   = 0;
        end
        push_expect(hit);
        step();
        i_spawn_valid = 1'b0;
        i_frame_tick  = 1'b0;
        compare_out();
    endtask

    task automatic pixel(input int x, input int y);
        bit e;
        i_x = 16'(x);
        i_y = 16'(y);
        step();
        e = model_pixel(x, y);
        check("sprite_hit", o_sprite_hit, e);
        check("rgb", {o_red, o_green, o_blue}, e ? 24'hC04020 : 24'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_active", o_lane_active, 0);
        check("rst_count", o_passed_count, 0);
        check("rst_hit", o_hit, 0);
        check("rst_hit_lane", o_hit_lane, 0);
        check("rst_sprite", o_sprite_hit, 0);
        check("rst_rgb", {o_red, o_green, o_blue}, 0);
        i_rst_n = 1'b1;
        step();

        // Render window around lane 0 at y=100, then let it scroll off.
        spawn(0, 1'b0, 1, 1'b0);
        ticks(25, 1, 1'b0);
        pixel(170, 110);
        pixel(224, 110);
        pixel(223, 131);
        pixel(170, 132);
        pixel(170, 99);
        pixel(300, 110);
        ticks(95, 1, 1'b0);

        // Busy lane and out-of-range lanes are refused.
        spawn(1, 1'b0, 0, 1'b0);
        spawn(1, 1'b0, 0, 1'b0);
        spawn(5, 1'b0, 0, 1'b0);
        spawn(3, 1'b0, 0, 1'b0);

        // Asynchronous reset mid-scroll with a visible sprite and a nonzero count.
        ticks(50, 0, 1'b0);
        pixel(300, 210);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_active", o_lane_active, 0);
        check("mid_rst_rgb", {o_red, o_green, o_blue}, 0);
        check("mid_rst_sprite", o_sprite_hit, 0);
        check("mid_rst_count", o_passed_count, 0);
        model_reset();
        step();
        i_rst_n = 1'b1;
        step();

        // Grounded collision on lane 2, then the lane report holds.
        spawn(2, 1'b0, 2, 1'b0);
        ticks(100, 2, 1'b0);
        ticks(3, 2, 1'b0);

        // Airborne through the window; spawn into the clearing lane on its retire tick.
        spawn(2, 1'b0, 2, 1'b1);
        ticks(119, 2, 1'b1);
        spawn(2, 1'b1, 2, 1'b1);
        tick(2, 1'b1);

        // Spawn and tick together on an idle lane: the new obstacle is not advanced.
        spawn(0, 1'b1, 1, 1'b0);
        pixel(165, 0);
        pixel(165, 32);
        pixel(165, 35);
        ticks(120, 1, 1'b0);

        // Two lanes at equal y; player hit on lane 0 then jumps across to lane 2.
        spawn(0, 1'b0, 0, 1'b0);
        spawn(2, 1'b0, 0, 1'b0);
        ticks(100, 0, 1'b0);
        ticks(10, 2, 1'b1);
        ticks(10, 2, 1'b0);

        // Three lanes retire on the same tick.
        spawn(0, 1'b0, 0, 1'b1);
        spawn(1, 1'b0, 0, 1'b1);
        spawn(2, 1'b0, 0, 1'b1);
        ticks(120, 0, 1'b1);
        check("final_count", o_passed_count, 16'(m_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
